// File: rtl/msched_pkg.sv
// Shared definitions for the motion scheduler: motor mode encodings,
// speech command codes, FSM state constants and the command decoder.
package msched_pkg;

  // Motor mode encodings driven onto the mode output
  localparam logic [2:0] MODE_STOP  = 3'b000;
  localparam logic [2:0] MODE_RIGHT = 3'b001;
  localparam logic [2:0] MODE_LEFT  = 3'b010;
  localparam logic [2:0] MODE_FWD   = 3'b011;
  localparam logic [2:0] MODE_BACK  = 3'b100;

  // Speech command codes
  localparam logic [7:0] CMD_FORWARD   = 8'd111;
  localparam logic [7:0] CMD_BACKWARD  = 8'd251;
  localparam logic [7:0] CMD_TURN_L    = 8'd247;
  localparam logic [7:0] CMD_TURN_R    = 8'd186;
  localparam logic [7:0] CMD_UTURN     = 8'd183;
  localparam logic [7:0] CMD_ROTATE_L  = 8'd105;
  localparam logic [7:0] CMD_ROTATE_R  = 8'd217;

  // FSM state enumeration
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_TIMED = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Which duration parameter a timed manoeuvre uses
  localparam logic [1:0] DUR_TURN  = 2'd0;
  localparam logic [1:0] DUR_UTURN = 2'd1;
  localparam logic [1:0] DUR_ROT   = 2'd2;

  typedef struct packed {
    logic [1:0] state;
    logic [2:0] dir;
    logic [1:0] dur_sel;
  } cmd_decode_t;

  // Map a speech code to its target state, direction and duration class
  function automatic cmd_decode_t decode_cmd(input logic [7:0] code);
    cmd_decode_t d;
    d = '{state: ST_IDLE, dir: MODE_STOP, dur_sel: DUR_TURN};
    case (code)
      CMD_FORWARD:  d = '{state: ST_RUN,   dir: MODE_FWD,   dur_sel: DUR_TURN};
      CMD_BACKWARD: d = '{state: ST_RUN,   dir: MODE_BACK,  dur_sel: DUR_TURN};
      CMD_TURN_L:   d = '{state: ST_TIMED, dir: MODE_LEFT,  dur_sel: DUR_TURN};
      CMD_TURN_R:   d = '{state: ST_TIMED, dir: MODE_RIGHT, dur_sel: DUR_TURN};
      CMD_UTURN:    d = '{state: ST_TIMED, dir: MODE_LEFT,  dur_sel: DUR_UTURN};
      CMD_ROTATE_L: d = '{state: ST_TIMED, dir: MODE_LEFT,  dur_sel: DUR_ROT};
      CMD_ROTATE_R: d = '{state: ST_TIMED, dir: MODE_RIGHT, dur_sel: DUR_ROT};
      default:      d = '{state: ST_IDLE,  dir: MODE_STOP,  dur_sel: DUR_TURN};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/duration_timer.sv
// Pausable manoeuvre timer. load restarts the count at 0 and latches the
// duration; the count advances only while pause is low and stops at
// duration-1, where expire is raised for that unpaused cycle.
module duration_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         pause,
  input  logic [W-1:0] duration,
  output logic         expire
);

  logic [W-1:0] count_reg;
  logic [W-1:0] dur_reg;
  logic         at_end;

  assign at_end = (count_reg == dur_reg - W'(1));
  assign expire = !load && !pause && at_end;

  // Count register: cleared on load, held while paused or at its end value
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      dur_reg   <= W'(1);
    end else if (load) begin
      count_reg <= '0;
      dur_reg   <= duration;
    end else if (!pause && !at_end) begin
      count_reg <= count_reg + W'(1);
    end
  end

endmodule

// File: rtl/motion_sched.sv
// Motion scheduler: turns accepted speech commands into motor modes, times
// turn/u-turn/rotate manoeuvres, applies the obstacle override and hands
// control to the follow logic when follow_en is high.
// Optional macro MSCHED_REVERSE_EN: an obstacle during a timed manoeuvre
// drives backward instead of stop.
module motion_sched
  import msched_pkg::*;
#(
  parameter int unsigned TURN_CYC  = 67108864,
  parameter int unsigned UTURN_CYC = 134217728,
  parameter int unsigned ROT_CYC   = 268435456
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_code,
  output logic       cmd_ready,
  input  logic       follow_en,
  input  logic [2:0] follow_mode,
  input  logic       near,
  output logic [2:0] mode,
  output logic       busy,
  output logic       done,
  output logic       alarm
);

  localparam int unsigned MAX_A   = (TURN_CYC > UTURN_CYC) ? TURN_CYC : UTURN_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > ROT_CYC) ? MAX_A : ROT_CYC;
  localparam int          CNT_W   = $clog2(MAX_CYC) + 1;

`ifdef MSCHED_REVERSE_EN
  localparam logic [2:0] OBST_TIMED_MODE = MODE_BACK;
`else
  localparam logic [2:0] OBST_TIMED_MODE = MODE_STOP;
`endif

  logic [1:0]       state_reg, state_next;
  logic [2:0]       dir_reg, dir_next;
  logic [2:0]       mode_reg, mode_next;
  logic             done_reg;
  logic             alarm_reg;
  logic             accept;
  logic             expire;
  logic             timer_load;
  logic             timer_pause;
  logic [CNT_W-1:0] duration;
  cmd_decode_t      dec;

  assign cmd_ready   = !follow_en && (state_reg != ST_TIMED);
  assign accept      = cmd_valid && cmd_ready;
  assign dec         = decode_cmd(cmd_code);
  assign timer_load  = accept && (dec.state == ST_TIMED);
  // Outside TIMED, under an obstacle, or in follow mode the clock stands still
  assign timer_pause = near || follow_en || (state_reg != ST_TIMED);

  // Pick the duration of the manoeuvre being loaded
  always_comb begin
    duration = CNT_W'(TURN_CYC);
    case (dec.dur_sel)
      DUR_UTURN: duration = CNT_W'(UTURN_CYC);
      DUR_ROT:   duration = CNT_W'(ROT_CYC);
      default:   duration = CNT_W'(TURN_CYC);
    endcase
  end

  duration_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .pause    (timer_pause),
    .duration (duration),
    .expire   (expire)
  );

  // Next state, remembered direction and the mode that goes with them
  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    if (accept) begin
      state_next = dec.state;
      dir_next   = dec.dir;
    end else if ((state_reg == ST_TIMED) && expire) begin
      state_next = ST_HOLD;
      dir_next   = MODE_STOP;
    end
    if (near) begin
      mode_next = (state_next == ST_TIMED) ? OBST_TIMED_MODE : MODE_STOP;
    end else if ((state_next == ST_RUN) || (state_next == ST_TIMED)) begin
      mode_next = dir_next;
    end else begin
      mode_next = MODE_STOP;
    end
  end

  // State and output registers; follow mode overrides everything but reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      dir_reg   <= MODE_STOP;
      mode_reg  <= MODE_STOP;
      done_reg  <= 1'b0;
      alarm_reg <= 1'b0;
    end else if (follow_en) begin
      state_reg <= ST_IDLE;
      dir_reg   <= MODE_STOP;
      mode_reg  <= follow_mode;
      done_reg  <= 1'b0;
      alarm_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      dir_reg   <= dir_next;
      mode_reg  <= mode_next;
      done_reg  <= (state_reg == ST_TIMED) && expire;
      alarm_reg <= near;
    end
  end

  assign mode  = mode_reg;
  assign busy  = (state_reg == ST_TIMED);
  assign done  = done_reg;
  assign alarm = alarm_reg;

endmodule

// File: tb/tb_motion_sched.sv
// Directed testbench for motion_sched with short manoeuvre durations
// (turn 8, u-turn 12, rotate 16 cycles).
module tb_motion_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic       cmd_ready;
  logic       follow_en;
  logic [2:0] follow_mode;
  logic       near;
  logic [2:0] mode;
  logic       busy;
  logic       done;
  logic       alarm;

  int checks   = 0;
  int failures = 0;

`ifdef MSCHED_REVERSE_EN
  localparam logic [2:0] OBS_MODE = 3'b100;
`else
  localparam logic [2:0] OBS_MODE = 3'b000;
`endif

  motion_sched #(
    .TURN_CYC  (8),
    .UTURN_CYC (12),
    .ROT_CYC   (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .cmd_ready   (cmd_ready),
    .follow_en   (follow_en),
    .follow_mode (follow_mode),
    .near        (near),
    .mode        (mode),
    .busy        (busy),
    .done        (done),
    .alarm       (alarm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [7:0] code;
    logic       fen;
    logic [2:0] fm;
    logic       nr;
    logic [2:0] e_mode;
    logic       e_busy;
    logic       e_done;
    logic       e_alarm;
    logic       e_ready;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a timed command and follow it to completion; near is raised for
  // nl cycles starting at cycle ns of the manoeuvre.
  task automatic run_timed(input string name, input logic [7:0] code,
                           input logic [2:0] dir, input int exp_len,
                           input int ns, input int nl);
    int  len;
    int  i;
    logic prev_near;
    cmd_valid = 1'b1;
    cmd_code  = code;
    step();
    cmd_valid = 1'b0;
    check({name, "_start_mode"}, mode, dir);
    check({name, "_start_busy"}, busy, 1);
    check({name, "_start_ready"}, cmd_ready, 0);
    len = 1;
    i   = 1;
    while (busy && i < 100) begin
      near      = (i >= ns) && (i < ns + nl);
      prev_near = near;
      step();
      if (busy) begin
        len++;
        check({name, "_mode"}, mode, prev_near ? OBS_MODE : dir);
        check({name, "_alarm"}, alarm, prev_near);
        check({name, "_done_early"}, done, 0);
        check({name, "_ready"}, cmd_ready, 0);
      end else begin
        check({name, "_end_done"}, done, 1);
        check({name, "_end_mode"}, mode, 0);
        check({name, "_end_ready"}, cmd_ready, 1);
      end
      i++;
    end
    near = 1'b0;
    check({name, "_timeout"}, (i >= 100) ? 1 : 0, 0);
    check({name, "_length"}, len, exp_len);
    step();
    check({name, "_hold_done"}, done, 0);
    check({name, "_hold_busy"}, busy, 0);
    check({name, "_hold_mode"}, mode, 0);
  endtask

  initial begin
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_code    = 8'd0;
    follow_en   = 1'b0;
    follow_mode = 3'd0;
    near        = 1'b0;

    //            valid code     fen fm    nr  mode    bsy dn al rdy
    vecs[0]  = '{1'b1, 8'd111, 1'b0, 3'd0, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b1, 8'd251, 1'b0, 3'd0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 8'd0,   1'b0, 3'd0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 8'd0,   1'b0, 3'd0, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 8'd99,  1'b0, 3'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 8'd0,   1'b1, 3'd1, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'd0,   1'b1, 3'd3, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'd0,   1'b0, 3'd3, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 8'd111, 1'b1, 3'd2, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'd0,   1'b0, 3'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 8'd111, 1'b0, 3'd0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    step();
    step();
    check("rst_mode", mode, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_alarm", alarm, 0);
    check("rst_ready", cmd_ready, 1);
    rst = 1'b0;

    // Single-cycle vectors: inputs applied for one edge, outputs checked after it
    for (int v = 0; v < 11; v++) begin
      cmd_valid   = vecs[v].valid;
      cmd_code    = vecs[v].code;
      follow_en   = vecs[v].fen;
      follow_mode = vecs[v].fm;
      near        = vecs[v].nr;
      step();
      check($sformatf("vec%0d_mode", v), mode, vecs[v].e_mode);
      check($sformatf("vec%0d_busy", v), busy, vecs[v].e_busy);
      check($sformatf("vec%0d_done", v), done, vecs[v].e_done);
      check($sformatf("vec%0d_alarm", v), alarm, vecs[v].e_alarm);
      check($sformatf("vec%0d_ready", v), cmd_ready, vecs[v].e_ready);
      $display("vec %0d: code=%0d fen=%0b near=%0b -> mode=%03b busy=%0b done=%0b alarm=%0b ready=%0b",
               v, vecs[v].code, vecs[v].fen, vecs[v].nr, mode, busy, done, alarm, cmd_ready);
    end
    cmd_valid   = 1'b0;
    follow_en   = 1'b0;
    follow_mode = 3'd0;
    near        = 1'b0;

    // Timed manoeuvres, including restart from HOLD and an obstacle pause
    run_timed("turn_l", 8'd247, 3'b010, 8, 0, 0);
    $display("seq turn_l done");
    run_timed("turn_l_again", 8'd247, 3'b010, 8, 0, 0);
    $display("seq turn_l_again done");
    run_timed("turn_r_near", 8'd186, 3'b001, 13, 3, 5);
    $display("seq turn_r_near done");
    run_timed("uturn", 8'd183, 3'b010, 12, 0, 0);
    $display("seq uturn done");
    run_timed("rot_r", 8'd217, 3'b001, 16, 0, 0);
    $display("seq rot_r done");

    // U-turn aborted by follow mode at cycle 4
    cmd_valid = 1'b1;
    cmd_code  = 8'd183;
    step();
    cmd_valid = 1'b0;
    check("abort_busy0", busy, 1);
    step();
    step();
    follow_en   = 1'b1;
    follow_mode = 3'b011;
    step();
    check("follow_busy", busy, 0);
    check("follow_mode1", mode, 3'b011);
    check("follow_done", done, 0);
    check("follow_alarm", alarm, 0);
    check("follow_ready", cmd_ready, 0);
    follow_mode = 3'b001;
    near        = 1'b1;
    check("follow_lag", mode, 3'b011);
    step();
    check("follow_mode2", mode, 3'b001);
    check("follow_near_alarm", alarm, 0);
    for (int k = 0; k < 12; k++) begin
      step();
      check("follow_no_done", done, 0);
    end
    near      = 1'b0;
    follow_en = 1'b0;
    step();
    check("unfollow_mode", mode, 0);
    check("unfollow_busy", busy, 0);
    check("unfollow_ready", cmd_ready, 1);
    $display("seq follow_abort done");

    // Rotate aborted by reset at cycle 6; reset beats every other input
    cmd_valid = 1'b1;
    cmd_code  = 8'd105;
    step();
    cmd_valid = 1'b0;
    check("rot_l_busy", busy, 1);
    check("rot_l_mode", mode, 3'b010);
    for (int k = 0; k < 5; k++) step();
    rst       = 1'b1;
    near      = 1'b1;
    cmd_valid = 1'b1;
    cmd_code  = 8'd111;
    step();
    check("mid_rst_mode", mode, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_alarm", alarm, 0);
    check("mid_rst_ready", cmd_ready, 1);
    rst      = 1'b0;
    near     = 1'b0;
    cmd_code = 8'd99;
    step();
    cmd_valid = 1'b0;
    check("code99_mode", mode, 0);
    check("code99_busy", busy, 0);
    for (int k = 0; k < 20; k++) begin
      step();
      check("post_rst_no_done", done, 0);
      check("post_rst_idle", busy, 0);
    end
    $display("seq reset_abort done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motion_sched.md
MOTION_SCHED -- requirements
Module: motion_sched

Interface
REQ-001 SHALL have parameter TURN_CYC, default 67108864, meaning clk cycles of a left/right turn.
REQ-002 SHALL have parameter UTURN_CYC, default 134217728, meaning clk cycles of a u-turn.
REQ-003 SHALL have parameter ROT_CYC, default 268435456, meaning clk cycles of a rotate-left/rotate-right.
REQ-004 SHALL have port clk  input  1  system clock; the block uses one clock only.
REQ-005 SHALL have port rst  input  1  reset, synchronous to clk, active-high.
REQ-006 SHALL have port cmd_valid  input  1  command code offered.
REQ-007 SHALL have port cmd_code  input  8  speech command code.
REQ-008 SHALL have port cmd_ready  output  1  block accepts a command this cycle.
REQ-009 SHALL have port follow_en  input  1  follow mode selected (1) or speech mode selected (0).
REQ-010 SHALL have port follow_mode  input  3  motor mode requested by the follow logic.
REQ-011 SHALL have port near  input  1  obstacle closer than threshold.
REQ-012 SHALL have port mode  output  3  motor mode (000 stop, 001 right, 010 left, 011 forward, 100 backward).
REQ-013 SHALL have port busy  output  1  timed manoeuvre in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse when a timed manoeuvre completes.
REQ-015 SHALL have port alarm  output  1  obstacle alarm, which enables blink and sound.

Function
REQ-016 SHALL implement states IDLE, RUN, TIMED and HOLD.
REQ-017 SHALL assert cmd_ready = !follow_en && state!=TIMED; a command is accepted only when cmd_valid && cmd_ready.
REQ-018 SHALL decode accepted codes as follows.
- 111 -> RUN, forward.
- 251 -> RUN, backward.
- 247 -> TIMED, left, TURN_CYC.
- 186 -> TIMED, right, TURN_CYC.
- 183 -> TIMED, left, UTURN_CYC.
- 105 -> TIMED, left, ROT_CYC.
- 217 -> TIMED, right, ROT_CYC.
- Any other code -> IDLE, stop.
REQ-019 SHALL register mode so that it takes the decoded value on the cycle after acceptance, giving a latency of 1.
REQ-020 SHALL, in TIMED, count elapsed cycles only while near=0; the count starts at 0 on entry.
REQ-021 SHALL leave TIMED for HOLD on the cycle after the count reaches duration-1 with near=0, drive mode=stop, and pulse done for exactly one cycle.
REQ-022 SHALL hold mode=stop in HOLD until a command is accepted; re-accepting the same code restarts the manoeuvre from count 0.
REQ-023 SHALL keep the RUN direction until a command is accepted.
REQ-024 SHALL drive busy=1 if and only if state==TIMED.
REQ-025 SHALL apply the obstacle override on the registered mode when near=1.
- In TIMED, mode=backward if MSCHED_REVERSE_EN is defined, else stop.
- In all other states, mode=stop.
- Mode returns to the state's direction on the cycle after near falls.
REQ-026 SHALL register alarm as near && !follow_en.
REQ-027 SHALL, while follow_en=1, force the state to IDLE (aborting any TIMED without a done pulse), set mode=follow_mode registered (1-cycle latency) and set alarm=0; the near override does not apply.
REQ-028 SHALL, when follow_en falls, start in IDLE with mode=stop.
REQ-029 SHALL size the count register to ceil(log2(max duration))+1 bits and never let it wrap; a duration of 1 completes after one unpaused cycle.

Reset
REQ-030 SHALL, on rst=1 at a clk edge, set state=IDLE, count=0, mode=000, busy=0, done=0 and alarm=0, with cmd_ready following REQ-017.
REQ-031 SHALL let reset asserted mid-manoeuvre abort it without a done pulse, and SHALL let rst take priority over all inputs.

Configuration
REQ-032 SHALL support macro MSCHED_REVERSE_EN.
- Defined: an obstacle during TIMED drives backward.
- Undefined: an obstacle during TIMED drives stop.
- All other behaviour is identical in both builds.

Structure
REQ-033 SHALL place the mode encodings, the command code constants and the state enumeration in shared package msched_pkg.
REQ-034 SHALL implement the pausable duration counter as sub-module duration_timer, with load, pause and expire ports.

Verification (TURN_CYC=8, UTURN_CYC=12, ROT_CYC=16)
REQ-035 SHALL cover: code 111 accepted -> mode=011 next cycle, busy=0; then code 251 -> mode=100.
REQ-036 SHALL cover: code 247 -> mode=010 for 8 cycles, cmd_ready=0, busy=1; then mode=000, done high for 1 cycle, state HOLD.
REQ-037 SHALL cover: code 186 with near=1 for 5 cycles mid-turn -> mode=100 (macro defined) or 000 (macro undefined) for those cycles, alarm=1, and the turn lasts 13 cycles in total.
REQ-038 SHALL cover: code 183 then follow_en=1 at cycle 4 -> state IDLE, no done pulse, mode tracks follow_mode=011 with 1-cycle lag.
REQ-039 SHALL cover: code 105 then rst at cycle 6 -> all outputs 0 next cycle and cmd_ready=1; code 099 -> mode=000, state IDLE.
